// File: rtl/serial2parallel_pkg.sv
// serial2parallel_pkg: shared state type and frame length helper.
// Define S2P_PARITY_EN to append an even-parity bit to every frame.
package serial2parallel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } s2p_state_t;

  function automatic int frame_len(input int data_w);
`ifdef S2P_PARITY_EN
    return data_w + 1;
`else
    return data_w;
`endif
  endfunction

endpackage

// File: rtl/s2p_shift_core.sv
// s2p_shift_core: serial shifter, bit counter and bit-order mux.
// word shows the value including the bit sampled on this edge.
module s2p_shift_core
  import serial2parallel_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              clear,
  input  logic              din,
  output logic [DATA_W-1:0] word,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shifted;
  logic [CNT_W-1:0]  bit_cnt;

  always_comb begin
    if (MSB_FIRST) begin
      shifted = {shreg[DATA_W-2:0], din};
    end else begin
      shifted = {din, shreg[DATA_W-1:1]};
    end
  end

  assign word       = shift_en ? shifted : shreg;
  assign frame_done = shift_en &&
                      (bit_cnt == CNT_W'(DATA_W - 1));

  // clear wins over shift so a finished frame leaves a blank shifter
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg   <= shifted;
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial2parallel_gen.sv
// serial2parallel_gen: DATA_W-bit deserializer with ready/valid output.
// Define S2P_PARITY_EN for a trailing even-parity bit per frame.
module serial2parallel_gen
  import serial2parallel_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit GAP_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_serial,
  input  logic              din_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_parallel,
  output logic              dout_valid,
  output logic              overflow,
  output logic              parity_err
);

  s2p_state_t        state;
  logic              shift_en;
  logic              clear;
  logic              done;
  logic              gap;
  logic              frame_done;
  logic [DATA_W-1:0] word;

  assign gap = GAP_RESET && !din_valid && (state != IDLE);

  always_comb begin
    shift_en = din_valid && (state != PARITY);
`ifdef S2P_PARITY_EN
    done = din_valid && (state == PARITY);
`else
    done = frame_done;
`endif
    clear = done || gap;
  end

  s2p_shift_core #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .clear     (clear),
    .din       (din_serial),
    .word      (word),
    .frame_done(frame_done)
  );

`ifdef S2P_PARITY_EN
  logic par_bad;
  assign par_bad = (^word) ^ din_serial;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dout_parallel <= '0;
      dout_valid    <= 1'b0;
      overflow      <= 1'b0;
`ifdef S2P_PARITY_EN
      parity_err    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (din_valid) state <= SHIFT;
        end
        SHIFT: begin
          if (frame_done) begin
`ifdef S2P_PARITY_EN
            state <= PARITY;
`else
            state <= IDLE;
`endif
          end else if (gap) begin
            state <= IDLE;
          end
        end
        PARITY: begin
          if (done || gap) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      overflow <= 1'b0;
      if (done) begin
        if (!dout_valid || dout_ready) begin
          dout_parallel <= word;
          dout_valid    <= 1'b1;
`ifdef S2P_PARITY_EN
          parity_err    <= par_bad;
`endif
        end else begin
          overflow <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule
